// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI arbiter.
// State and owner encodings plus the timeout response word.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESP
  } state_t;

  typedef enum logic {
    OWN_INERT,
    OWN_A2D
  } owner_t;

  localparam logic [15:0] RESP_ERR = 16'hFFFF;

endpackage

// File: rtl/spi_arb_wdog.sv
// spi_wdog: BUSY-phase watchdog; expired rises one cycle after the
// count reaches TIMEOUT_CYC-1 and holds until cleared.
module spi_wdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [W-1:0] LIM = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (run) begin
      if (cnt != LIM) cnt <= cnt + W'(1);
      expired <= (cnt == LIM);
    end
  end

endmodule

// File: rtl/spi_arb.sv
// spi_arb: two-client SPI master arbiter (inertial / A2D) with
// starvation guard on A2D and a BUSY watchdog.
module spi_arb #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_STREAK  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inert_req,
  input  logic [15:0] inert_cmd,
  output logic        inert_gnt,
  output logic        inert_done,
  input  logic        a2d_req,
  input  logic [15:0] a2d_cmd,
  output logic        a2d_gnt,
  output logic        a2d_done,
  output logic [15:0] resp,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        spi_done,
  input  logic [15:0] rd_data,
  output logic        err
);

  import spi_arb_pkg::*;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);

  state_t     state, state_nx;
  owner_t     owner;
  logic [2:0] streak;
  logic       expired;
  logic       any_req;
  logic       pick_a2d;
  logic       launch;

  assign any_req  = inert_req | a2d_req;
  assign pick_a2d = a2d_req & (~inert_req | (streak == STREAK_MAX));
  assign launch   = (state == ST_IDLE) & any_req;

  spi_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_BUSY),
    .run     (state == ST_BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    wrt        = 1'b0;
    inert_gnt  = 1'b0;
    a2d_gnt    = 1'b0;
    inert_done = 1'b0;
    a2d_done   = 1'b0;
    unique case (state)
      ST_IDLE:   if (any_req) state_nx = ST_LAUNCH;
      ST_LAUNCH: state_nx = ST_BUSY;
      ST_BUSY:   if (spi_done || expired) state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (state != ST_IDLE) begin
      inert_gnt = (owner == OWN_INERT);
      a2d_gnt   = (owner == OWN_A2D);
    end
    if (state == ST_RESP) begin
      inert_done = (owner == OWN_INERT);
      a2d_done   = (owner == OWN_A2D);
    end
    if (state == ST_LAUNCH) wrt = 1'b1;
  end

  // spi_done has priority over the watchdog in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= OWN_INERT;
      streak <= '0;
      cmd    <= '0;
      resp   <= '0;
      err    <= 1'b0;
    end else begin
      if (launch) begin
        owner <= pick_a2d ? OWN_A2D : OWN_INERT;
        cmd   <= pick_a2d ? a2d_cmd : inert_cmd;
        if (pick_a2d)
          streak <= '0;
        else if (a2d_req && streak != STREAK_MAX)
          streak <= streak + 3'd1;
      end
      if (state == ST_BUSY) begin
        if (spi_done) begin
          resp <= rd_data;
        end else if (expired) begin
          resp <= RESP_ERR;
          err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: table, directed and random checks of spi_arb against
// a transaction-level arbitration/latency model.
module tb_spi_arb;

  localparam int TO = 16;
  localparam int MS = 4;

  typedef struct {
    logic ir;
    logic ar;
    logic ea;
  } arb_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inert_req, a2d_req, spi_done;
  logic [15:0] inert_cmd, a2d_cmd, rd_data;

  logic        inert_gnt, inert_done, a2d_gnt, a2d_done, wrt, err;
  logic [15:0] resp, cmd;
  logic        s_inert_gnt, s_inert_done, s_a2d_gnt, s_a2d_done;
  logic        s_wrt, s_err;
  logic [15:0] s_resp, s_cmd;

  int vectors;
  int miscompares;
  int m_streak;
  logic m_err;
  arb_vec_t tbl [14];

  always #5 clk = ~clk;

  spi_arb #(.TIMEOUT_CYC(TO), .MAX_STREAK(MS)) dut (
    .clk(clk), .rst(rst),
    .inert_req(inert_req), .inert_cmd(inert_cmd),
    .inert_gnt(inert_gnt), .inert_done(inert_done),
    .a2d_req(a2d_req), .a2d_cmd(a2d_cmd),
    .a2d_gnt(a2d_gnt), .a2d_done(a2d_done),
    .resp(resp), .wrt(wrt), .cmd(cmd),
    .spi_done(spi_done), .rd_data(rd_data), .err(err)
  );

  spi_arb s_dut (
    .clk(clk), .rst(rst),
    .inert_req(inert_req), .inert_cmd(inert_cmd),
    .inert_gnt(s_inert_gnt), .inert_done(s_inert_done),
    .a2d_req(a2d_req), .a2d_cmd(a2d_cmd),
    .a2d_gnt(s_a2d_gnt), .a2d_done(s_a2d_done),
    .resp(s_resp), .wrt(s_wrt), .cmd(s_cmd),
    .spi_done(spi_done), .rd_data(rd_data), .err(s_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_grant(input logic ir, input logic ar,
                             output logic ea);
    ea = ar && (!ir || m_streak == MS);
    if (ea) m_streak = 0;
    else if (ar) m_streak = (m_streak >= MS) ? MS : m_streak + 1;
  endtask

  // dj: BUSY-cycle index of spi_done; outside 0..TO means timeout
  task automatic run_txn(input logic ir, input logic ar,
                         input logic [15:0] ic, input logic [15:0] ac,
                         input logic [15:0] rd, input int dj,
                         input logic drop, input logic ea);
    logic        tmo;
    int          blen;
    logic [15:0] ecmd, eresp;
    tmo   = !(dj >= 0 && dj <= TO);
    blen  = tmo ? TO + 1 : dj + 1;
    eresp = tmo ? 16'hFFFF : rd;
    ecmd  = ea ? ac : ic;
    if (tmo) m_err = 1'b1;
    inert_req = ir; a2d_req = ar;
    inert_cmd = ic; a2d_cmd = ac;
    spi_done  = 1'b0;
    tick();
    chk("launch_wrt", wrt, 1);
    chk("launch_cmd", cmd, ecmd);
    chk("launch_gnt", {inert_gnt, a2d_gnt}, ea ? 2'b01 : 2'b10);
    if (drop) begin
      inert_req = 1'b0; a2d_req = 1'b0;
      inert_cmd = 16'($urandom); a2d_cmd = 16'($urandom);
    end
    tick();
    for (int j = 0; j < blen; j++) begin
      chk("busy_out", {wrt, inert_done, a2d_done}, 0);
      spi_done = (j == dj);
      rd_data  = (j == dj) ? rd : 16'($urandom);
      tick();
    end
    spi_done = 1'b0;
    chk("resp_done", {inert_done, a2d_done}, ea ? 2'b01 : 2'b10);
    chk("resp_gnt", {inert_gnt, a2d_gnt}, ea ? 2'b01 : 2'b10);
    chk("resp_data", resp, eresp);
    chk("resp_cmd", cmd, ecmd);
    chk("resp_wrt", wrt, 0);
    chk("err", err, m_err);
    tick();
    chk("idle_out", {wrt, inert_gnt, a2d_gnt, inert_done, a2d_done}, 0);
  endtask

  task automatic txn(input logic ir, input logic ar, input int dj,
                     input logic drop);
    logic ea;
    model_grant(ir, ar, ea);
    run_txn(ir, ar, 16'($urandom), 16'($urandom), 16'($urandom),
            dj, drop, ea);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   nwrt, ndone;
    logic ea;
    vectors = 0; miscompares = 0;
    m_streak = 0; m_err = 1'b0;
    rst = 1'b1; inert_req = 1'b0; a2d_req = 1'b0; spi_done = 1'b0;
    inert_cmd = '0; a2d_cmd = '0; rd_data = '0;
    tbl = '{
      '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0}
    };
    tick(); tick();
    chk("rst_ctl", {wrt, inert_gnt, a2d_gnt, inert_done, a2d_done, err}, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_resp", resp, 0);
    chk("rst_slow", {s_wrt, s_inert_gnt, s_a2d_gnt, s_inert_done,
                     s_a2d_done, s_err}, 0);
    rst = 1'b0;

    // long transaction on the default-timeout instance
    inert_req = 1'b1; inert_cmd = 16'hA2C3;
    tick();
    chk("s_launch_wrt", s_wrt, 1);
    chk("s_launch_cmd", s_cmd, 16'hA2C3);
    inert_req = 1'b0; inert_cmd = 16'h0000;
    nwrt = 1; ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      nwrt += int'(s_wrt);
      ndone += int'(s_inert_done) + int'(s_a2d_done);
    end
    spi_done = 1'b1; rd_data = 16'h1234;
    tick();
    spi_done = 1'b0;
    chk("s_done", {s_inert_done, s_a2d_done}, 2'b10);
    chk("s_resp", s_resp, 16'h1234);
    chk("s_cmd_held", s_cmd, 16'hA2C3);
    chk("s_early_done", ndone, 0);
    tick();
    nwrt += int'(s_wrt);
    chk("s_idle", {s_inert_done, s_inert_gnt, s_err}, 0);
    chk("s_wrt_count", nwrt, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    m_streak = 0; m_err = 1'b0;

    // spi_done on the very cycle the watchdog fires
    model_grant(1'b1, 1'b0, ea);
    run_txn(1'b1, 1'b0, 16'hA2AA, 16'h0000, 16'hBEEF, TO, 1'b1, ea);

    // stray spi_done while idle
    spi_done = 1'b1; rd_data = 16'h7777;
    tick();
    spi_done = 1'b0;
    chk("stray_idle", {wrt, inert_gnt, a2d_gnt, inert_done, a2d_done}, 0);
    chk("stray_resp", resp, 16'hBEEF);
    tick();
    chk("stray_idle2", {wrt, inert_done, a2d_done}, 0);

    // arbitration table, requests held between transactions
    for (int i = 0; i < 14; i++) begin
      model_grant(tbl[i].ir, tbl[i].ar, ea);
      run_txn(tbl[i].ir, tbl[i].ar, 16'hA200 + 16'(i), 16'h5500 + 16'(i),
              16'h1000 + 16'(i), 2, 1'b0, tbl[i].ea);
    end
    inert_req = 1'b0; a2d_req = 1'b0;

    // A2D timeout, then err must stay set
    txn(1'b0, 1'b1, -1, 1'b1);
    txn(1'b1, 1'b0, 3, 1'b1);

    // reset in the middle of BUSY
    inert_req = 1'b1;
    tick();
    inert_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_ctl", {wrt, inert_gnt, a2d_gnt, inert_done, a2d_done, err}, 0);
    chk("midrst_data", {cmd, resp}, 0);
    rst = 1'b0; m_streak = 0; m_err = 1'b0;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      ndone += int'(inert_done) + int'(a2d_done) + int'(wrt) + int'(inert_gnt);
    end
    chk("midrst_quiet", ndone, 0);
    txn(1'b1, 1'b0, 5, 1'b1);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      logic [1:0] r;
      int dj;
      if ($urandom_range(0, 4) == 0) begin
        inert_req = 1'b0; a2d_req = 1'b0;
        spi_done = 1'($urandom);
        tick();
        spi_done = 1'b0;
        chk("gap_idle", {wrt, inert_gnt, a2d_gnt, inert_done, a2d_done}, 0);
      end
      r  = 2'($urandom_range(1, 3));
      dj = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TO)) : -1;
      txn(r[0], r[1], dj, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
